// File: rtl/sys_defs.sv
// sys_defs: shared processor sizing constants and common types.
package sys_defs;
    localparam int WIDTH    = 2;
    localparam int PRF_SIZE = 64;
    localparam int RF_SIZE  = 32;
    localparam int FL_SIZE  = PRF_SIZE - RF_SIZE;
    localparam int PR_W     = $clog2(PRF_SIZE);

    localparam logic [PR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic            valid;
        logic [PR_W-1:0] tag;
    } cdb_t;
endpackage

// File: rtl/ss_freelist.sv
// ss_freelist: superscalar physical-register free list with commit-point rollback.
module ss_freelist #(
    parameter int WIDTH    = sys_defs::WIDTH,
    parameter int PRF_SIZE = sys_defs::PRF_SIZE,
    parameter int RF_SIZE  = sys_defs::RF_SIZE,
    parameter int FL_SIZE  = PRF_SIZE - RF_SIZE
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [WIDTH-1:0]                       dispatch_req,
    input  logic [WIDTH-1:0]                       retire_en,
    input  logic [WIDTH-1:0][$clog2(PRF_SIZE)-1:0] retire_prev_T,
    input  logic                                   rollback_en,
    output logic [WIDTH-1:0][$clog2(PRF_SIZE)-1:0] free_register,
    output logic [WIDTH-1:0]                       free_valid,
    output logic [$clog2(FL_SIZE):0]               free_count
);
    localparam int PR_W  = $clog2(PRF_SIZE);
    localparam int PTR_W = $clog2(FL_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] FL_MAX = (CNT_W + 1)'(FL_SIZE);

    logic [PR_W-1:0]  entry_q [FL_SIZE];
    logic [PR_W-1:0]  entry_d [FL_SIZE];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, commit_q, commit_d;
    logic [CNT_W-1:0] free_count_q, free_count_d;
    logic [CNT_W-1:0] pops, pushes;
    logic [CNT_W:0]   total;

    function automatic logic [CNT_W-1:0] count_below(input logic [WIDTH-1:0] v, input int n);
        count_below = '0;
        for (int i = 0; i < WIDTH; i++)
            if (i < n && v[i]) count_below = count_below + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] off);
        logic [CNT_W:0] s;
        s = {2'b0, p} + {1'b0, off};
        return s >= FL_MAX ? PTR_W'(s - FL_MAX) : PTR_W'(s);
    endfunction

    // Grants are compacted: each requesting lane takes the next entry after earlier requesters.
    always_comb begin
        for (int w = 0; w < WIDTH; w++) begin
            free_register[w] = entry_q[wrap_add(head_q, count_below(dispatch_req, w))];
            free_valid[w]    = dispatch_req[w] ? (count_below(dispatch_req, w) + 1'b1 <= free_count_q)
                                               : (CNT_W'(w) < free_count_q);
        end
    end

    assign free_count = free_count_q;

    always_comb begin
        pops    = count_below(dispatch_req & free_valid, WIDTH);
        pushes  = count_below(retire_en, WIDTH);
        entry_d = entry_q;
        for (int w = 0; w < WIDTH; w++)
            if (retire_en[w]) entry_d[wrap_add(tail_q, count_below(retire_en, w))] = retire_prev_T[w];
        tail_d       = wrap_add(tail_q, pushes);
        commit_d     = wrap_add(commit_q, pushes);
        head_d       = rollback_en ? commit_d : wrap_add(head_q, pops);
        total        = {1'b0, free_count_q} - {1'b0, pops} + {1'b0, pushes};
        free_count_d = rollback_en ? CNT_W'(FL_SIZE) : total[CNT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) entry_q[i] <= PR_W'(RF_SIZE + i);
            head_q       <= '0;
            tail_q       <= '0;
            commit_q     <= '0;
            free_count_q <= CNT_W'(FL_SIZE);
        end else begin
            entry_q      <= entry_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            commit_q     <= commit_d;
            free_count_q <= free_count_d;
        end
    end

    // Retiring more PRs than the list can hold means the caller freed a PR twice.
    always_ff @(posedge clock)
        if (!reset) assert (total <= FL_MAX);
endmodule

// File: tb/tb_ss_freelist.sv
// tb_ss_freelist: scenario tests for ss_freelist against a queue-based free-list model.
module tb_ss_freelist;
    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      dispatch_req, retire_en, free_valid;
    logic [1:0][5:0] retire_prev_T, free_register;
    logic            rollback_en;
    logic [5:0]      free_count;

    typedef struct {
        logic [1:0]      valid;
        logic [1:0]      known;
        logic [1:0][5:0] r;
        logic [5:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   fl[$];
    int   cfl[$];
    int   errors = 0;
    int   checks = 0;

    ss_freelist dut (
        .clock(clock), .reset(reset), .dispatch_req(dispatch_req), .retire_en(retire_en),
        .retire_prev_T(retire_prev_T), .rollback_en(rollback_en), .free_register(free_register),
        .free_valid(free_valid), .free_count(free_count)
    );

    always #5 clock = ~clock;

    task automatic reset_model();
        fl.delete();
        for (int i = 0; i < 32; i++) fl.push_back(32 + i);
        cfl = fl;
    endtask

    task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] ret,
                         input logic [5:0] p1, input logic [5:0] p0, input logic rb);
        exp_t x;
        int   k;
        reset = rst; dispatch_req = req; retire_en = ret; retire_prev_T = {p1, p0}; rollback_en = rb;
        k = 0;
        x.r = '0;
        for (int w = 0; w < 2; w++) begin
            x.valid[w] = req[w] ? (k + 1 <= fl.size()) : (w < fl.size());
            x.known[w] = k < fl.size();
            if (x.known[w]) x.r[w] = 6'(fl[k]);
            if (req[w]) k++;
        end
        x.cnt = 6'(fl.size());
        exp_q.push_back(x);
    endtask

    task automatic tick();
        int n;
        @(posedge clock);
        if (reset) reset_model();
        else begin
            if (!rollback_en) begin
                n = int'(dispatch_req[0]) + int'(dispatch_req[1]);
                if (n > fl.size()) n = fl.size();
                repeat (n) void'(fl.pop_front());
            end
            for (int w = 0; w < 2; w++)
                if (retire_en[w]) begin
                    cfl.push_back(int'(retire_prev_T[w]));
                    void'(cfl.pop_front());
                    if (!rollback_en) fl.push_back(int'(retire_prev_T[w]));
                end
            if (rollback_en) fl = cfl;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1, 2'b11, 2'b11, 6'd3, 6'd4, 1);
            else        drive(0, 2'b11, 2'b00, 6'd0, 6'd0, 0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (free_valid !== e.valid) begin errors++; $display("FAIL reset[%0d] free_valid got %b want %b", i, free_valid, e.valid); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL reset[%0d] free_count got %0d want %0d", i, free_count, e.cnt); end
            for (int w = 0; w < 2; w++) if (e.known[w]) begin
                checks++; if (free_register[w] !== e.r[w]) begin errors++; $display("FAIL reset[%0d] reg%0d got %0d want %0d", i, w, free_register[w], e.r[w]); end
            end
            if (i == 1) begin
                checks++; if (free_register !== {6'd33, 6'd32} || free_valid !== 2'b11 || free_count !== 6'd32) begin
                    errors++; $display("FAIL reset_const got reg=%0d,%0d valid=%b count=%0d want 33,32 11 32", free_register[1], free_register[0], free_valid, free_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_dual_dispatch();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, i == 0 ? 2'b00 : 2'b11, 2'b00, 6'd0, 6'd0, 0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (free_valid !== e.valid) begin errors++; $display("FAIL dual[%0d] free_valid got %b want %b", i, free_valid, e.valid); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL dual[%0d] free_count got %0d want %0d", i, free_count, e.cnt); end
            for (int w = 0; w < 2; w++) if (e.known[w]) begin
                checks++; if (free_register[w] !== e.r[w]) begin errors++; $display("FAIL dual[%0d] reg%0d got %0d want %0d", i, w, free_register[w], e.r[w]); end
            end
            if (i == 1) begin
                checks++; if (free_register !== {6'd33, 6'd32}) begin errors++; $display("FAIL dual_first got %0d,%0d want 33,32", free_register[1], free_register[0]); end
            end
            if (i == 2) begin
                checks++; if (free_register !== {6'd35, 6'd34} || free_count !== 6'd30) begin
                    errors++; $display("FAIL dual_second got %0d,%0d count=%0d want 35,34 30", free_register[1], free_register[0], free_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_lane();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, i == 1 ? 2'b10 : i == 2 ? 2'b01 : 2'b00, 2'b00, 6'd0, 6'd0, 0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (free_valid !== e.valid) begin errors++; $display("FAIL single[%0d] free_valid got %b want %b", i, free_valid, e.valid); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL single[%0d] free_count got %0d want %0d", i, free_count, e.cnt); end
            for (int w = 0; w < 2; w++) if (e.known[w]) begin
                checks++; if (free_register[w] !== e.r[w]) begin errors++; $display("FAIL single[%0d] reg%0d got %0d want %0d", i, w, free_register[w], e.r[w]); end
            end
            if (i == 1) begin
                checks++; if (free_register[1] !== 6'd32 || (free_valid & 2'b10) !== 2'b10) begin
                    errors++; $display("FAIL single_lane1 got reg1=%0d valid=%b want 32 1x", free_register[1], free_valid);
                end
            end
            if (i == 2) begin
                checks++; if (free_register[0] !== 6'd33) begin errors++; $display("FAIL single_lane0 got %0d want 33", free_register[0]); end
            end
            tick();
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 19; i++) begin
            drive(i == 0, i == 0 ? 2'b00 : 2'b11, 2'b00, 6'd0, 6'd0, 0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (free_valid !== e.valid) begin errors++; $display("FAIL drain[%0d] free_valid got %b want %b", i, free_valid, e.valid); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL drain[%0d] free_count got %0d want %0d", i, free_count, e.cnt); end
            for (int w = 0; w < 2; w++) if (e.known[w]) begin
                checks++; if (free_register[w] !== e.r[w]) begin errors++; $display("FAIL drain[%0d] reg%0d got %0d want %0d", i, w, free_register[w], e.r[w]); end
            end
            if (i >= 17) begin
                checks++; if (free_count !== 6'd0 || free_valid !== 2'b00) begin
                    errors++; $display("FAIL drain_empty[%0d] got count=%0d valid=%b want 0 00", i, free_count, free_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_refill();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(0, 2'b11, 2'b11, 6'd7, 6'd5, 0);
            else        drive(0, 2'b11, 2'b00, 6'd0, 6'd0, 0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (free_valid !== e.valid) begin errors++; $display("FAIL refill[%0d] free_valid got %b want %b", i, free_valid, e.valid); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL refill[%0d] free_count got %0d want %0d", i, free_count, e.cnt); end
            for (int w = 0; w < 2; w++) if (e.known[w]) begin
                checks++; if (free_register[w] !== e.r[w]) begin errors++; $display("FAIL refill[%0d] reg%0d got %0d want %0d", i, w, free_register[w], e.r[w]); end
            end
            if (i == 0) begin
                checks++; if (free_valid !== 2'b00) begin errors++; $display("FAIL refill_nobypass got %b want 00", free_valid); end
            end
            if (i == 1) begin
                checks++; if (free_register !== {6'd7, 6'd5} || free_count !== 6'd2 || free_valid !== 2'b11) begin
                    errors++; $display("FAIL refill_grant got %0d,%0d count=%0d valid=%b want 7,5 2 11", free_register[1], free_register[0], free_count, free_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_partial_grant();
        for (int i = 0; i < 19; i++) begin
            drive(i == 0, i == 0 ? 2'b00 : i == 16 ? 2'b01 : 2'b11, 2'b00, 6'd0, 6'd0, 0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (free_valid !== e.valid) begin errors++; $display("FAIL partial[%0d] free_valid got %b want %b", i, free_valid, e.valid); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL partial[%0d] free_count got %0d want %0d", i, free_count, e.cnt); end
            for (int w = 0; w < 2; w++) if (e.known[w]) begin
                checks++; if (free_register[w] !== e.r[w]) begin errors++; $display("FAIL partial[%0d] reg%0d got %0d want %0d", i, w, free_register[w], e.r[w]); end
            end
            if (i == 17) begin
                checks++; if (free_valid !== 2'b01 || free_count !== 6'd1 || free_register[0] !== 6'd63) begin
                    errors++; $display("FAIL partial_last got valid=%b count=%0d reg0=%0d want 01 1 63", free_valid, free_count, free_register[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 28; i++) begin
            if (i == 0 || i == 6)                 drive(1, 2'b00, 2'b00, 6'd0, 6'd0, 0);
            else if (i == 4)                      drive(0, 2'b00, 2'b00, 6'd0, 6'd0, 1);
            else if (i == 10)                     drive(0, 2'b11, 2'b01, 6'd0, 6'd9, 1);
            else if (i == 11)                     drive(0, 2'b00, 2'b00, 6'd0, 6'd0, 0);
            else if (i < 12)                      drive(0, 2'b01, 2'b00, 6'd0, 6'd0, 0);
            else                                  drive(0, 2'b11, 2'b00, 6'd0, 6'd0, 0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (free_valid !== e.valid) begin errors++; $display("FAIL rollback[%0d] free_valid got %b want %b", i, free_valid, e.valid); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL rollback[%0d] free_count got %0d want %0d", i, free_count, e.cnt); end
            for (int w = 0; w < 2; w++) if (e.known[w]) begin
                checks++; if (free_register[w] !== e.r[w]) begin errors++; $display("FAIL rollback[%0d] reg%0d got %0d want %0d", i, w, free_register[w], e.r[w]); end
            end
            if (i == 5) begin
                checks++; if (free_count !== 6'd32 || free_register[0] !== 6'd32) begin
                    errors++; $display("FAIL rollback_plain got count=%0d reg0=%0d want 32 32", free_count, free_register[0]);
                end
            end
            if (i == 11) begin
                checks++; if (free_count !== 6'd32 || free_register[0] !== 6'd33) begin
                    errors++; $display("FAIL rollback_retire got count=%0d reg0=%0d want 32 33", free_count, free_register[0]);
                end
            end
            if (i == 27) begin
                checks++; if (free_register[1] !== 6'd9 || free_register[0] !== 6'd63) begin
                    errors++; $display("FAIL rollback_entry0 got %0d,%0d want 9,63", free_register[1], free_register[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 35; i++) begin
            if (i == 0)       drive(1, 2'b00, 2'b00, 6'd0, 6'd0, 0);
            else if (i <= 16) drive(0, 2'b11, 2'b00, 6'd0, 6'd0, 0);
            else if (i <= 28) drive(0, 2'b00, 2'b11, 6'(i), 6'(i + 20), 0);
            else if (i == 29) drive(0, 2'b00, 2'b01, 6'd0, 6'd1, 0);
            else if (i <= 31) drive(0, 2'b11, 2'b00, 6'd0, 6'd0, 0);
            else if (i == 32) drive(0, 2'b01, 2'b00, 6'd0, 6'd0, 0);
            else if (i == 33) drive(1, 2'b11, 2'b11, 6'd2, 6'd3, 1);
            else              drive(0, 2'b11, 2'b00, 6'd0, 6'd0, 0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (free_valid !== e.valid) begin errors++; $display("FAIL midreset[%0d] free_valid got %b want %b", i, free_valid, e.valid); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL midreset[%0d] free_count got %0d want %0d", i, free_count, e.cnt); end
            for (int w = 0; w < 2; w++) if (e.known[w]) begin
                checks++; if (free_register[w] !== e.r[w]) begin errors++; $display("FAIL midreset[%0d] reg%0d got %0d want %0d", i, w, free_register[w], e.r[w]); end
            end
            if (i == 33) begin
                checks++; if (free_count !== 6'd20) begin errors++; $display("FAIL midreset_pre got count=%0d want 20", free_count); end
            end
            if (i == 34) begin
                checks++; if (free_register !== {6'd33, 6'd32} || free_valid !== 2'b11 || free_count !== 6'd32) begin
                    errors++; $display("FAIL midreset_post got %0d,%0d valid=%b count=%0d want 33,32 11 32", free_register[1], free_register[0], free_valid, free_count);
                end
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; dispatch_req = '0; retire_en = '0; retire_prev_T = '0; rollback_en = 1'b0;
        reset_model();
        @(posedge clock);
        #1;
        reset = 1'b0;
        test_reset();
        test_dual_dispatch();
        test_single_lane();
        test_drain();
        test_refill();
        test_partial_grant();
        test_rollback();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
